result_drain: RTL and testbench
===============================

# result_drain

Buffers the complex results produced by the ALU stage of the data path and drains them to an 8-bit consumer port with a valid/ready handshake. It sits directly downstream of the ALU: each result pair (real byte, imaginary byte), tagged with its 2-bit opcode, is pushed into a small FIFO. Entries are then serialised as two output beats, real first and imaginary second. Overflow is recorded in a sticky status flag rather than stalling the producer.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  pulses for one cycle when res_re/res_im/in_op hold a new result
- in_op  input  2  opcode that produced the result (ALU select bits)
- res_re  input  8  real part of result
- res_im  input  8  imaginary part of result
- clr_ovf  input  1  synchronous clear of the ovf flag
- out_valid  output  1  a beat is presented
- out_ready  input  1  consumer accepts a beat
- out_data  output  8  beat payload
- out_tag  output  2  opcode of the entry being drained
- out_last  output  1  high on the imaginary (second) beat of an entry
- count  output  $clog2(DEPTH)+1  occupied entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- ovf  output  1  sticky: a push was dropped

## Operation
- Storage: DEPTH x 18-bit entries {in_op, res_re, res_im}, with write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Push: when in_valid=1 and full=0, write the entry at wp and increment wp.
- Dropped push: when in_valid=1 and full=1, do not write, leave wp unchanged and set ovf. This holds even if the same cycle pops an entry; full is judged on the registered count.
- Phase register: PH_RE (0) / PH_IM (1).
- out_valid = !empty. A beat transfers when out_valid && out_ready.
- PH_RE: out_data = head.re, out_last = 0. A transfer moves the phase to PH_IM.
- PH_IM: out_data = head.im, out_last = 1. A transfer pops the head, increments rp and returns the phase to PH_RE.
- out_tag = head.op for both beats.
- When empty: out_data, out_tag and out_last are forced to 0.
- Count update: count += push_accepted − pop. Simultaneous accepted push and pop leaves count unchanged.
- ovf: set by a dropped push. A clr_ovf in the same cycle as a dropped push still leaves ovf=1 (set wins).
- Payload stability: the payload is stable while out_valid=1 and out_ready=0. The consumer may hold out_ready low indefinitely.
- The producer is never back-pressured. Results are written unchanged, with no arithmetic on the data.

## Timing
- Reset (async assert, sync-safe release) values: wp=0, rp=0, count=0, phase=PH_RE, ovf=0, out_valid=0, out_data=0, out_tag=0, out_last=0, full=0, empty=1.
- Storage array contents are not reset.
- Latency: a push at edge N makes out_valid=1 after edge N; the real beat is visible in cycle N+1. There is no same-cycle bypass from input to output.
- Throughput: with out_ready held high, one entry drains every 2 cycles. A producer pushing every cycle therefore fills the FIFO.
- Wrap: after DEPTH pushes and pops, both pointers return to 0 with no loss.
- Reset mid-entry (after the real beat, before the imaginary beat): the entry is discarded. After reset, out_valid=0 and phase=PH_RE.
- Pop on the last entry while a push arrives in the same cycle: the new entry is presented in the next cycle in PH_RE, and out_valid stays 1.

## Test plan
- Reset, then push {op=2, re=0x12, im=0x34} with out_ready=1: the cycle after the push shows out_data=0x12, out_tag=2, out_last=0; the next cycle shows out_data=0x34, out_last=1; then empty=1 and out_valid=0.
- Push 4 entries (re=0x10..0x13, im=0x20..0x23) with out_ready=0: full=1, count=4. A 5th push sets ovf=1 and count stays 4. Release out_ready: the bytes appear in order 10,20,11,21,12,22,13,23.
- Back-pressure: hold out_ready=0 for 5 cycles while in PH_IM of entry 0xAB/0xCD: out_data stays 0xCD and out_last stays 1 throughout, with no pop until the handshake.
- Full FIFO with a push and the final beat of the head transferring in the same cycle: the push is dropped, ovf=1, count=3. Then assert clr_ovf alone: ovf=0.
- Wrap: 10 consecutive single pushes, each drained before the next: all 20 bytes are correct and wp=rp=2 at the end (DEPTH=4).
- Assert rst_n low after the real beat of an entry is consumed: all outputs return to their reset values immediately. After release, a new push drains starting from its real beat.

Source files
------------

// File: rtl/result_drain.sv
// result_drain: small FIFO that buffers complex ALU results and drains each
// entry to an 8-bit consumer as two valid/ready beats (real, then imaginary).
// Overflowing pushes are dropped and recorded in a sticky flag; the producer
// is never stalled.
module result_drain #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [1:0]                 in_op,
  input  logic [7:0]                 res_re,
  input  logic [7:0]                 res_im,
  input  logic                       clr_ovf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic [1:0]                 out_tag,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry layout: {op[17:16], re[15:8], im[7:0]}
  typedef struct packed {
    logic [1:0] op;
    logic [7:0] re;
    logic [7:0] im;
  } entry_t;

  typedef enum logic {
    PH_RE = 1'b0,
    PH_IM = 1'b1
  } phase_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wp_reg, wp_next;
  logic [AW-1:0]   rp_reg, rp_next;
  logic [CW-1:0]   count_reg, count_next;
  phase_t          phase_reg, phase_next;
  logic            ovf_reg, ovf_next;

  logic push_ok;
  logic push_drop;
  logic beat_fire;
  logic pop;

  // Full/empty are judged on the registered count only, so a same-cycle pop
  // never rescues a push into a full FIFO.
  assign full      = (count_reg == DEPTH_C);
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign ovf       = ovf_reg;
  assign push_ok   = in_valid && !full;
  assign push_drop = in_valid && full;
  assign beat_fire = !empty && out_ready;
  assign pop       = beat_fire && (phase_reg == PH_IM);
  assign head      = mem[rp_reg];

  // Storage write: contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp_reg] <= '{op: in_op, re: res_re, im: res_im};
    end
  end

  // Pointer, count and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      wp_reg    <= wp_next;
      rp_reg    <= rp_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Next pointers, occupancy and sticky overflow (set beats clear)
  always_comb begin
    wp_next    = wp_reg;
    rp_next    = rp_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    if (push_ok) begin
      wp_next = wp_reg + 1'b1;
    end
    if (pop) begin
      rp_next = rp_reg + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    if (push_drop) begin
      ovf_next = 1'b1;
    end else if (clr_ovf) begin
      ovf_next = 1'b0;
    end
  end

  // Beat phase state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= PH_RE;
    end else begin
      phase_reg <= phase_next;
    end
  end

  // Beat phase next-state and output payload; payload follows head and phase
  // only, so it holds steady while the consumer stalls
  always_comb begin
    phase_next = phase_reg;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_tag    = 2'b00;
    out_last   = 1'b0;
    if (!empty) begin
      out_valid = 1'b1;
      out_tag   = head.op;
      case (phase_reg)
        PH_RE: begin
          out_data = head.re;
          out_last = 1'b0;
          if (beat_fire) begin
            phase_next = PH_IM;
          end
        end
        PH_IM: begin
          out_data = head.im;
          out_last = 1'b1;
          if (beat_fire) begin
            phase_next = PH_RE;
          end
        end
        default: phase_next = PH_RE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain (DEPTH=4): handshake order, overflow,
// back-pressure, wrap, async reset mid-entry and pop/push collision.
module tb_result_drain;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_op;
  logic [7:0] res_re;
  logic [7:0] res_im;
  logic       clr_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_tag;
  logic       out_last;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       ovf;

  int vectors;
  int miscompares;

  result_drain #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_op     (in_op),
    .res_re    (res_re),
    .res_im    (res_im),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_last  (out_last),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] op, input logic [7:0] re, input logic [7:0] im);
    in_valid = v;
    in_op    = op;
    res_re   = re;
    res_im   = im;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
    check({tag, "_tag"},   32'(out_tag),   32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
    check({tag, "_count"}, 32'(count),     32'd0);
    check({tag, "_full"},  32'(full),      32'd0);
    check({tag, "_empty"}, 32'(empty),     32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clr_ovf     = 1'b0;
    out_ready   = 1'b0;
    set_in(1'b0, 2'd0, 8'h00, 8'h00);

    // Reset values
    tick();
    tick();
    check_reset_outputs("reset");
    check("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    // Wrap: 10 single pushes, each drained before the next
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, 2'(k % 4), 8'(8'h30 + k), 8'(8'hC0 + k));
      tick();
      set_in(1'b0, 2'd0, 8'h00, 8'h00);
      check($sformatf("wrap%0d_re", k), 32'(out_data), 32'(8'h30 + k));
      check($sformatf("wrap%0d_tag", k), 32'(out_tag), 32'(k % 4));
      check($sformatf("wrap%0d_last0", k), 32'(out_last), 32'd0);
      tick();
      check($sformatf("wrap%0d_im", k), 32'(out_data), 32'(8'hC0 + k));
      check($sformatf("wrap%0d_last1", k), 32'(out_last), 32'd1);
      tick();
      check($sformatf("wrap%0d_empty", k), 32'(empty), 32'd1);
    end
    check("wrap_wp", 32'(dut.wp_reg), 32'd2);
    check("wrap_rp", 32'(dut.rp_reg), 32'd2);

    // Single entry op=2, 12/34
    set_in(1'b1, 2'd2, 8'h12, 8'h34);
    tick();
    set_in(1'b0, 2'd0, 8'h00, 8'h00);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_re", 32'(out_data), 32'h12);
    check("single_tag", 32'(out_tag), 32'd2);
    check("single_last0", 32'(out_last), 32'd0);
    tick();
    check("single_im", 32'(out_data), 32'h34);
    check("single_last1", 32'(out_last), 32'd1);
    check("single_tag1", 32'(out_tag), 32'd2);
    tick();
    check("single_empty", 32'(empty), 32'd1);
    check("single_valid0", 32'(out_valid), 32'd0);
    check("single_data0", 32'(out_data), 32'd0);

    // Fill with out_ready low, then overflow
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'(i), 8'(8'h10 + i), 8'(8'h20 + i));
      tick();
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    check("fill_ovf0", 32'(ovf), 32'd0);
    set_in(1'b1, 2'd3, 8'h99, 8'h98);
    tick();
    set_in(1'b0, 2'd0, 8'h00, 8'h00);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      check($sformatf("drain%0d_data", b), 32'(out_data),
            (b % 2 == 0) ? 32'(8'h10 + b / 2) : 32'(8'h20 + b / 2));
      check($sformatf("drain%0d_last", b), 32'(out_last), 32'(b % 2));
      check($sformatf("drain%0d_tag", b), 32'(out_tag), 32'(b / 2));
      tick();
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_ovf_sticky", 32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Back-pressure in the imaginary phase
    set_in(1'b1, 2'd1, 8'hAB, 8'hCD);
    tick();
    set_in(1'b0, 2'd0, 8'h00, 8'h00);
    check("bp_re", 32'(out_data), 32'hAB);
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_data", c), 32'(out_data), 32'hCD);
      check($sformatf("bp%0d_last", c), 32'(out_last), 32'd1);
      check($sformatf("bp%0d_count", c), 32'(count), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_popped", 32'(empty), 32'd1);

    // Full FIFO: push collides with the head's final beat and is dropped
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'd3, 8'(8'h40 + i), 8'(8'h50 + i));
      tick();
    end
    set_in(1'b0, 2'd0, 8'h00, 8'h00);
    out_ready = 1'b1;
    tick();
    check("col_im_head", 32'(out_data), 32'h50);
    set_in(1'b1, 2'd0, 8'h77, 8'h78);
    tick();
    set_in(1'b0, 2'd0, 8'h00, 8'h00);
    out_ready = 1'b0;
    check("col_ovf", 32'(ovf), 32'd1);
    check("col_count", 32'(count), 32'd3);
    check("col_head_re", 32'(out_data), 32'h41);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("col_clr", 32'(ovf), 32'd0);
    check("col_count_hold", 32'(count), 32'd3);
    out_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      check($sformatf("col_drain%0d", b), 32'(out_data),
            (b % 2 == 0) ? 32'(8'h41 + b / 2) : 32'(8'h51 + b / 2));
      tick();
    end
    check("col_empty", 32'(empty), 32'd1);

    // Pop of last entry coincides with a new push
    set_in(1'b1, 2'd1, 8'h61, 8'h62);
    tick();
    set_in(1'b0, 2'd0, 8'h00, 8'h00);
    tick();
    set_in(1'b1, 2'd2, 8'h63, 8'h64);
    tick();
    set_in(1'b0, 2'd0, 8'h00, 8'h00);
    check("pp_valid", 32'(out_valid), 32'd1);
    check("pp_re", 32'(out_data), 32'h63);
    check("pp_last", 32'(out_last), 32'd0);
    check("pp_tag", 32'(out_tag), 32'd2);
    check("pp_count", 32'(count), 32'd1);
    tick();
    tick();
    check("pp_empty", 32'(empty), 32'd1);

    // Reset mid-entry after the real beat
    set_in(1'b1, 2'd1, 8'h5A, 8'hA5);
    tick();
    set_in(1'b0, 2'd0, 8'h00, 8'h00);
    tick();
    check("mid_im", 32'(out_data), 32'hA5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_after_valid", 32'(out_valid), 32'd0);
    set_in(1'b1, 2'd0, 8'h66, 8'h67);
    tick();
    set_in(1'b0, 2'd0, 8'h00, 8'h00);
    check("mid_new_re", 32'(out_data), 32'h66);
    check("mid_new_last", 32'(out_last), 32'd0);
    tick();
    check("mid_new_im", 32'(out_data), 32'h67);
    tick();
    check("mid_new_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
